// File: rtl/pixel_sequencer.sv
// Raster-scan sample source for generate_ray: walks every pixel of a frame, issuing
// SAMPLES_PER_PIXEL samples per pixel under stall back-pressure. Define PIXEL_SEQ_SERPENTINE_EN for boustrophedon scan.
module pixel_sequencer #(
  parameter int PIXEL_WIDTH       = 800,
  parameter int PIXEL_HEIGHT      = 600,
  parameter int SAMPLES_PER_PIXEL = 4,
  parameter int X_W               = 10,
  parameter int Y_W               = 10,
  parameter int S_W               = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           stall,
  output logic [X_W-1:0] pixel_x,
  output logic [Y_W-1:0] pixel_y,
  output logic [S_W-1:0] sample_idx,
  output logic           pixel_valid,
  output logic           last_sample,
  output logic           frame_done,
  output logic           busy
);

  localparam logic [X_W-1:0] X_MAX = X_W'(PIXEL_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(PIXEL_HEIGHT - 1);
  localparam logic [S_W-1:0] S_MAX = S_W'(SAMPLES_PER_PIXEL - 1);
`ifdef PIXEL_SEQ_SERPENTINE_EN
  localparam logic [X_W-1:0] X_FINAL = (PIXEL_HEIGHT % 2 == 0) ? '0 : X_MAX;
`else
  localparam logic [X_W-1:0] X_FINAL = X_MAX;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [S_W-1:0] s_q, s_d;
  logic           valid_q, valid_d;
  logic           last_q, last_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic           fwd;
  logic           row_end;

`ifdef PIXEL_SEQ_SERPENTINE_EN
  assign fwd = ~y_q[0];
`else
  assign fwd = 1'b1;
`endif
  assign row_end = fwd ? (x_q == X_MAX) : (x_q == '0);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    s_d     = s_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          x_d     = '0;
          y_d     = '0;
          s_d     = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          last_d  = 1'b0;
        end
      end
      RUN: begin
        if (!stall) begin
          if (last_q) begin
            // Final sample consumed: coordinates hold on the final pixel through DONE.
            state_d = DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            if (s_q != S_MAX) begin
              s_d = s_q + S_W'(1);
            end else begin
              s_d = '0;
              if (!row_end) begin
                x_d = fwd ? x_q + X_W'(1) : x_q - X_W'(1);
              end else begin
`ifndef PIXEL_SEQ_SERPENTINE_EN
                x_d = '0;
`endif
                y_d = y_q + Y_W'(1);
              end
            end
            last_d = (s_d == S_MAX) && (x_d == X_FINAL) && (y_d == Y_MAX);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        x_d     = '0;
        y_d     = '0;
        s_d     = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      s_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      s_q     <= s_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign sample_idx  = s_q;
  assign pixel_valid = valid_q;
  assign last_sample = last_q;
  assign frame_done  = done_q;
  assign busy        = busy_q;

endmodule
